// File: rtl/saes_pkg.sv
// Shared S-AES mix-column definitions: GF(2^4) helpers, FSM states and data types.
package saes_pkg;

    typedef logic [3:0]  nibble_t;
    typedef logic [15:0] saes_state_t;

    typedef struct packed {
        nibble_t top;
        nibble_t bot;
    } col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        DONE = 2'd3
    } mix_state_e;

    // Low bits of x^4+x+1: an overflowing x^4 folds back as x+1.
    localparam nibble_t GF4_POLY_LOW = 4'h3;

    localparam nibble_t MUL2 = 4'h2;
    localparam nibble_t MUL4 = 4'h4;
    localparam nibble_t MUL9 = 4'h9;

    function automatic nibble_t gf_xtime(input nibble_t n);
        return {n[2:0], 1'b0} ^ (n[3] ? GF4_POLY_LOW : 4'h0);
    endfunction

    // Shift-and-add multiply; collapses to a few XORs when k is a constant.
    function automatic nibble_t gf_mul(input nibble_t n, input nibble_t k);
        nibble_t acc;
        nibble_t p;
        acc = 4'h0;
        p   = n;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/saes_mixcol_col.sv
// Combinational single-column mix: dir=1 inverse [[9,2],[2,9]], dir=0 forward [[1,4],[4,1]].
module saes_mixcol_col
    import saes_pkg::*;
(
    input  logic       dir,
    input  logic [7:0] col_in,
    output logic [7:0] col_out
);

    col_t c_in;
    col_t c_out;

    assign c_in = col_t'(col_in);

    always_comb begin
        c_out = '0;
        if (dir) begin
            c_out.top = gf_mul(c_in.top, MUL9) ^ gf_mul(c_in.bot, MUL2);
            c_out.bot = gf_mul(c_in.top, MUL2) ^ gf_mul(c_in.bot, MUL9);
        end else begin
            c_out.top = c_in.top ^ gf_mul(c_in.bot, MUL4);
            c_out.bot = gf_mul(c_in.top, MUL4) ^ c_in.bot;
        end
    end

    assign col_out = c_out;

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Sequential S-AES inverse MixColumns, one column per cycle through a shared column unit.
// Define INVMIX_DIR_SEL_EN to add a dir port selecting forward (0) or inverse (1).
module inv_mixcolumn_seq
    import saes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
`ifdef INVMIX_DIR_SEL_EN
    input  logic        dir,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out
);

    mix_state_e  state_q, state_d;
    saes_state_t in_q;
    logic        load;
    logic        dir_sel;
    logic [7:0]  col_in;
    logic [7:0]  col_out;

`ifdef INVMIX_DIR_SEL_EN
    logic dir_q;

    always_ff @(posedge clk) begin
        if (rst)       dir_q <= 1'b1;
        else if (load) dir_q <= dir;
    end

    assign dir_sel = dir_q;
`else
    assign dir_sel = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = COL0;
                end
            end
            COL0: state_d = COL1;
            COL1: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign col_in = (state_q == COL1) ? in_q[7:0] : in_q[15:8];

    saes_mixcol_col u_col (
        .dir     (dir_sel),
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            in_q     <= '0;
            data_out <= '0;
        end else begin
            state_q <= state_d;
            if (load)             in_q           <= data_in;
            if (state_q == COL0)  data_out[15:8] <= col_out;
            if (state_q == COL1)  data_out[7:0]  <= col_out;
        end
    end

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Randomized self-checking bench for inv_mixcolumn_seq against a GF(2^4) polynomial model.
module tb_inv_mixcolumn_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
`ifdef INVMIX_DIR_SEL_EN
    logic        dir;
`endif

    int          n_vec;
    int          n_err;
    logic [15:0] got;

    inv_mixcolumn_seq dut (
        .clk       (clk),
        .rst       (rst),
`ifdef INVMIX_DIR_SEL_EN
        .dir       (dir),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Carry-less polynomial product reduced modulo x^4+x+1.
    function automatic logic [3:0] ref_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if ((b >> i) & 1) p = p ^ (a << i);
        for (int i = 6; i >= 4; i--)
            if ((p >> i) & 1) p = p ^ (32'h13 << (i - 4));
        return 4'(p);
    endfunction

    function automatic logic [15:0] ref_mix(input logic [15:0] s, input logic dr);
        int a, b;
        int n[4];
        logic [3:0] r[4];
        a = dr ? 9 : 1;
        b = dr ? 2 : 4;
        for (int i = 0; i < 4; i++) n[i] = int'(s[15 - 4*i -: 4]);
        for (int c = 0; c < 2; c++) begin
            r[2*c]   = ref_mul(a, n[2*c]) ^ ref_mul(b, n[2*c+1]);
            r[2*c+1] = ref_mul(b, n[2*c]) ^ ref_mul(a, n[2*c+1]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // One transfer: checks latency, pulse width and hold-under-stall; leaves result in got.
    task automatic xfer(input logic [15:0] d, input logic dr, input int stall);
        logic [15:0] exp;
        int t;
        exp = ref_mix(d, dr);
        t = 0;
        @(negedge clk);
        data_in   = d;
`ifdef INVMIX_DIR_SEL_EN
        dir       = dr;
`endif
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {15'b0, in_ready}, 16'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_col0_valid", {15'b0, out_valid}, 16'h0);
        @(negedge clk);
        chk("lat_col1_valid", {15'b0, out_valid}, 16'h0);
        @(negedge clk);
        chk("done_valid", {15'b0, out_valid}, 16'h1);
        chk("done_data", data_out, exp);
        got = data_out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {15'b0, out_valid}, 16'h1);
            chk("stall_data", data_out, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("pulse_end_valid", {15'b0, out_valid}, 16'h0);
        chk("idle_hold_data", data_out, exp);
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] fw;
        logic        rd;
        n_vec     = 0;
        n_err     = 0;
        got       = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
`ifdef INVMIX_DIR_SEL_EN
        dir       = 1'b1;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {15'b0, in_ready}, 16'h1);
        chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
        chk("rst_data_out", data_out, 16'h0000);

        // Abort in COL1: reset for two cycles, nothing must emerge.
        data_in  = 16'h1400;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", {15'b0, in_ready}, 16'h1);
        chk("abort_out_valid", {15'b0, out_valid}, 16'h0);
        chk("abort_data_out", data_out, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_emit", {15'b0, out_valid}, 16'h0);
        end

        xfer(16'h1400, 1'b1, 0); chk("vec_1400", got, 16'h1000);
        xfer(16'h0001, 1'b1, 0); chk("vec_0001", got, 16'h0029);
        xfer(16'hFFFF, 1'b1, 0); chk("vec_ffff", got, 16'h3333);
        xfer(16'h0000, 1'b1, 0); chk("vec_0000", got, 16'h0000);

        // Backpressure with a competing in_valid that must not be consumed.
        @(negedge clk);
        data_in   = 16'h1000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 data_in = 16'hFFFF;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {15'b0, out_valid}, 16'h1);
            chk("bp_in_ready", {15'b0, in_ready}, 16'h0);
            chk("bp_data", data_out, 16'h9200);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {15'b0, in_ready}, 16'h1);
        chk("bp_release_valid", {15'b0, out_valid}, 16'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_next_valid", {15'b0, out_valid}, 16'h1);
        chk("bp_next_data", data_out, 16'h3333);
        @(negedge clk);
        chk("bp_next_end", {15'b0, out_valid}, 16'h0);

`ifdef INVMIX_DIR_SEL_EN
        xfer(16'h1000, 1'b0, 0); chk("fwd_1000", got, 16'h1400);
        xfer(16'h1400, 1'b1, 0); chk("inv_1400", got, 16'h1000);
        for (int i = 0; i < 12; i++) begin
            r = 16'($urandom);
            xfer(r, 1'b0, int'($urandom_range(0, 2)));
            fw = got;
            xfer(fw, 1'b1, int'($urandom_range(0, 2)));
            chk("round_trip", got, r);
        end
`endif

        for (int i = 0; i < 30; i++) begin
            r = 16'($urandom);
`ifdef INVMIX_DIR_SEL_EN
            rd = 1'($urandom);
`else
            rd = 1'b1;
`endif
            xfer(r, rd, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
